// File: rtl/bin_to_dec_seq_if.sv
// rtl/bin_to_dec_seq_if.sv - handshake bundle for the sequential binary-to-decimal converter
interface bin_to_dec_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bin;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_digits;
  logic                  out_mode;
  logic                  out_overflow;

  // Converter side
  modport slave (
    input  in_valid, in_bin, in_mode, out_ready,
    output in_ready, out_valid, out_digits, out_mode, out_overflow
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_bin, in_mode, out_ready,
    input  in_ready, out_valid, out_digits, out_mode, out_overflow
  );
endinterface

// File: rtl/bin_to_dec_seq.sv
// rtl/bin_to_dec_seq.sv - shift-and-add-3 binary to BCD/Excess-3 converter with valid/ready handshake
module bin_to_dec_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  bin_to_dec_seq_if.slave bus
);
  localparam int DW  = 4 * DIGITS;
  localparam int SRW = DW + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [SRW-1:0]  sr;
  logic [SRW-1:0]  sr_adj;
  logic [SRW-1:0]  sr_shift;
  logic [CW-1:0]   count;
  logic            mode_q;
  logic            ovf_acc;
  logic            accept;
  logic            last_step;
  logic [DW-1:0]   dig_fin;
  logic [DW-1:0]   dig_e3;
  logic [DW-1:0]   out_digits_q;
  logic            out_mode_q;
  logic            out_ovf_q;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (state == SHIFT) && (count == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_step)     state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come from the registered state only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Add 3 to every digit >= 5 ahead of the shift; digits do not carry into each other
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH + 4*i +: 4] >= 4'd5)
        sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
    end
  end

  assign sr_shift = {sr_adj[SRW-2:0], 1'b0};
  assign dig_fin  = sr_shift[SRW-1 -: DW];

  // Excess-3 recoding of the finished digits
  always_comb begin
    dig_e3 = '0;
    for (int i = 0; i < DIGITS; i++)
      dig_e3[4*i +: 4] = dig_fin[4*i +: 4] + 4'd3;
  end

  // Conversion datapath: load on accept, one double-dabble step per SHIFT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      count   <= '0;
      mode_q  <= 1'b0;
      ovf_acc <= 1'b0;
    end else if (accept) begin
      sr      <= {{DW{1'b0}}, bus.in_bin};
      count   <= '0;
      mode_q  <= bus.in_mode;
      ovf_acc <= 1'b0;
    end else if (state == SHIFT) begin
      sr      <= sr_shift;
      count   <= count + CW'(1);
      // A bit leaving the top digit is worth 10^DIGITS, so the result wraps
      ovf_acc <= ovf_acc | sr_adj[SRW-1];
    end
  end

  // Result registers, captured on the final step and held through HOLD and IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_digits_q <= '0;
      out_mode_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else if (last_step) begin
      out_digits_q <= mode_q ? dig_e3 : dig_fin;
      out_mode_q   <= mode_q;
      out_ovf_q    <= ovf_acc | sr_adj[SRW-1];
    end
  end

  assign bus.out_digits   = out_digits_q;
  assign bus.out_mode     = out_mode_q;
  assign bus.out_overflow = out_ovf_q;
endmodule
